button_evt_ctrl: RTL and testbench

Multi-button front-end controller. It debounces NB_BUTTONS raw inputs using a single shared millisecond prescaler and per-button millisecond counters. It turns each debounced edge into a press/release event, and round-robin arbitrates the pending events onto one valid/ready event port for the downstream UI/register logic.

---
 rtl/button_evt_ctrl.sv | 142 ++++++++++++++
 tb/tb_button_evt_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_evt_ctrl.sv
// Multi-button front end: two-flop sync, shared 1 ms prescaler, per-button debounce,
// press/release event capture and round-robin arbitration onto one valid/ready port.
module button_evt_ctrl #(
  parameter int CLK_FREQ        = 95_000,
  parameter int DEBOUNCE_PER_MS = 20,
  parameter int NB_BUTTONS      = 4,
  localparam int IW = (NB_BUTTONS > 1) ? $clog2(NB_BUTTONS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NB_BUTTONS-1:0] button_in,
  output logic [NB_BUTTONS-1:0] button_valid,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [IW-1:0]         evt_idx,
  output logic                  evt_press,
  output logic                  evt_overrun
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int CW = $clog2(DEBOUNCE_PER_MS + 1);

  logic [NB_BUTTONS-1:0] r_sync_p0;
  logic [NB_BUTTONS-1:0] r_sync_p1;
  logic [PW-1:0]         r_presc;
  logic [NB_BUTTONS-1:0] r_stable;
  logic [CW-1:0]         r_cnt [NB_BUTTONS];
  logic [NB_BUTTONS-1:0] r_pend;
  logic [NB_BUTTONS-1:0] r_ptype;
  logic [IW-1:0]         r_ptr;

  logic                  w_tick;
  logic [NB_BUTTONS-1:0] w_mism;
  logic [NB_BUTTONS-1:0] w_toggle;
  logic                  w_free;
  logic                  w_any;
  logic [IW-1:0]         w_gidx;
  logic [IW-1:0]         w_scan;
  logic                  w_gnt;
  logic [NB_BUTTONS-1:0] w_gnt_oh;

  assign button_valid = r_stable;

  // Stage p0/p1: double-flop synchroniser
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
    end else begin
      r_sync_p0 <= button_in;
      r_sync_p1 <= r_sync_p0;
    end
  end

  assign w_tick = (r_presc == PW'(CLK_FREQ - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_comb begin
    w_mism   = r_sync_p1 ^ r_stable;
    w_toggle = '0;
    for (int i = 0; i < NB_BUTTONS; i++) begin
      w_toggle[i] = w_mism[i] && w_tick && (r_cnt[i] == CW'(DEBOUNCE_PER_MS - 1));
    end
  end

  // Scan starts one past the last granted index so every button gets a fair turn
  always_comb begin
    w_any  = 1'b0;
    w_gidx = '0;
    w_scan = r_ptr;
    for (int k = 0; k < NB_BUTTONS; k++) begin
      w_scan = (w_scan == IW'(NB_BUTTONS - 1)) ? '0 : w_scan + 1'b1;
      if (r_pend[w_scan] && !w_any) begin
        w_any  = 1'b1;
        w_gidx = w_scan;
      end
    end
  end

  assign w_free   = !evt_valid || evt_ready;
  assign w_gnt    = w_free && w_any;
  assign w_gnt_oh = w_gnt ? (NB_BUTTONS'(1) << w_gidx) : '0;

  // Stage debounce: counters, stable levels, pending events
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NB_BUTTONS; i++) begin
        r_cnt[i] <= '0;
      end
      r_stable    <= '0;
      r_pend      <= '0;
      r_ptype     <= '0;
      evt_overrun <= 1'b0;
    end else begin
      for (int i = 0; i < NB_BUTTONS; i++) begin
        if (!w_mism[i]) begin
          r_cnt[i] <= '0;
        end else if (w_tick) begin
          r_cnt[i] <= w_toggle[i] ? '0 : r_cnt[i] + 1'b1;
        end
        // A toggle wins over a same-cycle grant: the grant carries the old type
        if (w_toggle[i]) begin
          r_stable[i] <= ~r_stable[i];
          r_pend[i]   <= 1'b1;
          r_ptype[i]  <= ~r_stable[i];
        end else if (w_gnt_oh[i]) begin
          r_pend[i]   <= 1'b0;
        end
      end
      evt_overrun <= |(w_toggle & r_pend & ~w_gnt_oh);
    end
  end

  // Stage output: event register held under backpressure
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evt_valid <= 1'b0;
      evt_idx   <= '0;
      evt_press <= 1'b0;
      r_ptr     <= IW'(NB_BUTTONS - 1);
    end else if (w_free) begin
      if (w_any) begin
        evt_valid <= 1'b1;
        evt_idx   <= w_gidx;
        evt_press <= r_ptype[w_gidx];
        r_ptr     <= w_gidx;
      end else begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_evt_ctrl.sv
// Directed bench for button_evt_ctrl with a 10-cycle ms tick, 3 ms debounce, 4 buttons.
module tb_button_evt_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] button_in = 4'h0;
  logic [3:0] button_valid;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [1:0] evt_idx;
  logic       evt_press;
  logic       evt_overrun;

  int nvec = 0;
  int nerr = 0;

  int q_idx[$];
  int q_press[$];
  int q_cyc[$];
  int cyc  = 0;
  int vcyc = 0;
  int ovr  = 0;

  button_evt_ctrl #(.CLK_FREQ(10), .DEBOUNCE_PER_MS(3), .NB_BUTTONS(4)) dut (
    .clk(clk), .rst(rst), .button_in(button_in), .button_valid(button_valid),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_idx(evt_idx),
    .evt_press(evt_press), .evt_overrun(evt_overrun)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after posedge, so negedge sees what the next edge will use
  always @(negedge clk) begin
    cyc++;
    if (rst && evt_valid && evt_ready) begin
      q_idx.push_back(int'(evt_idx));
      q_press.push_back(int'(evt_press));
      q_cyc.push_back(cyc);
    end
    if (evt_valid) vcyc++;
    if (evt_overrun) ovr++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    q_idx.delete();
    q_press.delete();
    q_cyc.delete();
    vcyc = 0;
    ovr  = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    button_in = 4'hF;
    tick(5);
    nvec++;
    if ({button_valid, evt_valid, evt_idx, evt_press, evt_overrun} !== 9'h0) begin
      nerr++;
      $display("FAIL reset_outputs: got %b want 000000000",
               {button_valid, evt_valid, evt_idx, evt_press, evt_overrun});
    end
    rst = 1'b1;
    button_in = 4'h0;
    clear_log();
    tick(300);
    nvec++;
    if (vcyc !== 0 || q_idx.size() !== 0) begin
      nerr++;
      $display("FAIL idle_no_event: valid cycles %0d events %0d want 0 0", vcyc, q_idx.size());
    end
    nvec++;
    if (button_valid !== 4'h0) begin
      nerr++;
      $display("FAIL idle_button_valid: got %h want 0", button_valid);
    end
  endtask

  task automatic test_single_press();
    int n;
    evt_ready = 1'b1;
    clear_log();
    button_in[1] = 1'b1;
    n = 0;
    while (!button_valid[1] && n < 100) begin
      tick(1);
      n++;
    end
    nvec++;
    if (n < 23 || n > 32) begin
      nerr++;
      $display("FAIL press_latency: got %0d cycles want 23..32", n);
    end
    tick(10);
    nvec++;
    if (q_idx.size() !== 1 || vcyc !== 1) begin
      nerr++;
      $display("FAIL press_count: events %0d valid cycles %0d want 1 1", q_idx.size(), vcyc);
    end else if (q_idx[0] !== 1 || q_press[0] !== 1) begin
      nerr++;
      $display("FAIL press_event: idx %0d press %0d want 1 1", q_idx[0], q_press[0]);
    end
    button_in[1] = 1'b0;
    tick(40);
    nvec++;
    if (q_idx.size() !== 2) begin
      nerr++;
      $display("FAIL release_count: events %0d want 2", q_idx.size());
    end else if (q_idx[1] !== 1 || q_press[1] !== 0) begin
      nerr++;
      $display("FAIL release_event: idx %0d press %0d want 1 0", q_idx[1], q_press[1]);
    end
  endtask

  task automatic test_bounce();
    clear_log();
    for (int s = 0; s < 8; s++) begin
      button_in[0] = (s % 2 == 0);
      tick(15);
    end
    nvec++;
    if (q_idx.size() !== 0 || button_valid[0] !== 1'b0) begin
      nerr++;
      $display("FAIL bounce_quiet: events %0d bv0 %b want 0 0", q_idx.size(), button_valid[0]);
    end
    button_in[0] = 1'b1;
    tick(40);
    nvec++;
    if (q_idx.size() !== 1) begin
      nerr++;
      $display("FAIL bounce_settle_count: events %0d want 1", q_idx.size());
    end else if (q_idx[0] !== 0 || q_press[0] !== 1) begin
      nerr++;
      $display("FAIL bounce_settle_event: idx %0d press %0d want 0 1", q_idx[0], q_press[0]);
    end
    button_in[0] = 1'b0;
    tick(40);
  endtask

  task automatic test_round_robin();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    evt_ready = 1'b0;
    button_in = 4'hF;
    clear_log();
    tick(60);
    nvec++;
    if (evt_valid !== 1'b1 || evt_idx !== 2'd0 || q_idx.size() !== 0) begin
      nerr++;
      $display("FAIL rr_blocked: valid %b idx %0d events %0d want 1 0 0", evt_valid, evt_idx, q_idx.size());
    end
    evt_ready = 1'b1;
    tick(8);
    nvec++;
    if (q_idx.size() !== 4) begin
      nerr++;
      $display("FAIL rr_count: events %0d want 4", q_idx.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        nvec++;
        if (q_idx[i] !== i || q_press[i] !== 1 || q_cyc[i] !== q_cyc[0] + i) begin
          nerr++;
          $display("FAIL rr_event%0d: idx %0d press %0d cyc +%0d want %0d 1 +%0d",
                   i, q_idx[i], q_press[i], q_cyc[i] - q_cyc[0], i, i);
        end
      end
    end
    evt_ready = 1'b0;
    clear_log();
    button_in[1] = 1'b0;
    tick(40);
    button_in[0] = 1'b0;
    button_in[3] = 1'b0;
    tick(60);
    evt_ready = 1'b1;
    tick(8);
    nvec++;
    if (q_idx.size() !== 3) begin
      nerr++;
      $display("FAIL rr_wrap_count: events %0d want 3", q_idx.size());
    end else if (q_idx[0] !== 1 || q_idx[1] !== 3 || q_idx[2] !== 0 ||
                 q_press[0] !== 0 || q_press[1] !== 0 || q_press[2] !== 0) begin
      nerr++;
      $display("FAIL rr_wrap_order: got %0d %0d %0d want 1 3 0 (all release)",
               q_idx[0], q_idx[1], q_idx[2]);
    end
    nvec++;
    if (button_valid !== 4'b0100) begin
      nerr++;
      $display("FAIL rr_levels: got %b want 0100", button_valid);
    end
  endtask

  task automatic test_overrun();
    button_in[2] = 1'b0;
    tick(40);
    clear_log();
    evt_ready = 1'b0;
    button_in[1] = 1'b1;
    tick(40);
    button_in[2] = 1'b1;
    tick(60);
    button_in[2] = 1'b0;
    tick(60);
    nvec++;
    if (ovr !== 1) begin
      nerr++;
      $display("FAIL overrun_pulses: got %0d want 1", ovr);
    end
    evt_ready = 1'b1;
    tick(8);
    nvec++;
    if (q_idx.size() !== 2) begin
      nerr++;
      $display("FAIL overrun_count: events %0d want 2", q_idx.size());
    end else if (q_idx[0] !== 1 || q_press[0] !== 1 || q_idx[1] !== 2 || q_press[1] !== 0) begin
      nerr++;
      $display("FAIL overrun_events: got (%0d,%0d) (%0d,%0d) want (1,1) (2,0)",
               q_idx[0], q_press[0], q_idx[1], q_press[1]);
    end
    nvec++;
    if (button_valid !== 4'b0010) begin
      nerr++;
      $display("FAIL overrun_levels: got %b want 0010", button_valid);
    end
  endtask

  task automatic test_reset_mid();
    evt_ready = 1'b0;
    button_in = 4'b0011;
    tick(40);
    nvec++;
    if (evt_valid !== 1'b1 || evt_idx !== 2'd0 || evt_press !== 1'b1 || button_valid !== 4'b0011) begin
      nerr++;
      $display("FAIL midrst_setup: valid %b idx %0d press %b bv %b want 1 0 1 0011",
               evt_valid, evt_idx, evt_press, button_valid);
    end
    button_in = 4'b1011;
    tick(12);
    rst = 1'b0;
    #2;
    nvec++;
    if ({button_valid, evt_valid, evt_idx, evt_press, evt_overrun} !== 9'h0) begin
      nerr++;
      $display("FAIL midrst_async: got %b want 000000000",
               {button_valid, evt_valid, evt_idx, evt_press, evt_overrun});
    end
    tick(3);
    rst = 1'b1;
    evt_ready = 1'b1;
    clear_log();
    tick(20);
    nvec++;
    if (q_idx.size() !== 0 || vcyc !== 0 || button_valid !== 4'h0) begin
      nerr++;
      $display("FAIL midrst_stale: events %0d valid cycles %0d bv %b want 0 0 0000",
               q_idx.size(), vcyc, button_valid);
    end
    tick(40);
    nvec++;
    if (q_idx.size() !== 3) begin
      nerr++;
      $display("FAIL midrst_fresh_count: events %0d want 3", q_idx.size());
    end else if (q_idx[0] !== 0 || q_idx[1] !== 1 || q_idx[2] !== 3 ||
                 q_press[0] !== 1 || q_press[1] !== 1 || q_press[2] !== 1) begin
      nerr++;
      $display("FAIL midrst_fresh_events: got %0d %0d %0d want 0 1 3 (all press)",
               q_idx[0], q_idx[1], q_idx[2]);
    end
    nvec++;
    if (button_valid !== 4'b1011) begin
      nerr++;
      $display("FAIL midrst_levels: got %b want 1011", button_valid);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single_press();
    test_bounce();
    test_round_robin();
    test_overrun();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
